// File: rtl/sim_sequencer_if.sv
// rtl/sim_sequencer_if.sv - load/step handshake between the run-control sequencer and the physics engine
interface sim_sequencer_if;
  logic load;
  logic step_req;
  logic step_done;

  modport master (output load, output step_req, input step_done);
  modport slave  (input load, input step_req, output step_done);
endinterface

// File: rtl/sim_sequencer.sv
// rtl/sim_sequencer.sv - run-control sequencer pacing physics steps to frame ticks
// Optional single-step button path is built only when SIM_SINGLE_STEP_EN is defined.
module sim_debounce #(
  parameter int W        = 1,
  parameter int DEBOUNCE = 4
) (
  input  logic         clock_162,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [W-1:0]  s1, s2, prev;
  logic [CW-1:0] cnt, cnt_next;

  // cnt_next = number of consecutive cycles s2 has held its current value
  always_comb begin
    if (s2 != prev)
      cnt_next = CW'(1);
    else if (cnt < CW'(DEBOUNCE))
      cnt_next = cnt + CW'(1);
    else
      cnt_next = cnt;
  end

  always_ff @(posedge clock_162) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      cnt  <= cnt_next;
      if (cnt_next == CW'(DEBOUNCE))
        deb <= s2;
    end
  end
endmodule

module sim_sequencer #(
  parameter int DEBOUNCE    = 1_620_000,
  parameter int LOAD_CYCLES = 4,
  parameter int TICK_DIV    = 1,
  parameter int OVR_W       = 8
) (
  input  logic             clock_162,
  input  logic             rst,
  input  logic [15:0]      sel,
  input  logic             pause_btn,
  input  logic             step_btn,
  input  logic             frame_tick,
  sim_sequencer_if.master  eng,
  output logic [15:0]      scenario,
  output logic             running,
  output logic [31:0]      step_count,
  output logic [OVR_W-1:0] overruns
);
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  localparam int DW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_STEP} state_t;

  state_t            state, state_d;
  logic [LW-1:0]     load_cnt, load_cnt_d;
  logic [DW-1:0]     div, div_d;
  logic [15:0]       scenario_d, sel_deb;
  logic              load_q, load_d, step_req_q, step_req_d, running_d;
  logic [31:0]       step_count_d;
  logic [OVR_W-1:0]  overruns_d;
  logic              pause_deb, pause_deb_q, pause_press, step_press;
  logic              div_done, load_done, sel_changed;

  sim_debounce #(.W(16), .DEBOUNCE(DEBOUNCE)) u_sel_db (
    .clock_162(clock_162), .rst(rst), .raw(sel), .deb(sel_deb)
  );

  sim_debounce #(.W(1), .DEBOUNCE(DEBOUNCE)) u_pause_db (
    .clock_162(clock_162), .rst(rst), .raw(pause_btn), .deb(pause_deb)
  );

  assign pause_press = pause_deb & ~pause_deb_q;

`ifdef SIM_SINGLE_STEP_EN
  logic step_deb, step_deb_q;

  sim_debounce #(.W(1), .DEBOUNCE(DEBOUNCE)) u_step_db (
    .clock_162(clock_162), .rst(rst), .raw(step_btn), .deb(step_deb)
  );

  always_ff @(posedge clock_162) begin
    if (rst) step_deb_q <= 1'b0;
    else     step_deb_q <= step_deb;
  end

  assign step_press = step_deb & ~step_deb_q;
`else
  logic unused_step_btn;
  assign unused_step_btn = step_btn;
  assign step_press      = 1'b0;
`endif

  assign div_done    = (div == DW'(TICK_DIV - 1));
  assign load_done   = (load_cnt == LW'(LOAD_CYCLES));
  assign sel_changed = (sel_deb != scenario);

  always_ff @(posedge clock_162) begin
    if (rst) begin
      state       <= S_LOAD;
      load_cnt    <= '0;
      div         <= '0;
      scenario    <= '0;
      load_q      <= 1'b0;
      step_req_q  <= 1'b0;
      running     <= 1'b0;
      step_count  <= '0;
      overruns    <= '0;
      pause_deb_q <= 1'b0;
    end else begin
      state       <= state_d;
      load_cnt    <= load_cnt_d;
      div         <= div_d;
      scenario    <= scenario_d;
      load_q      <= load_d;
      step_req_q  <= step_req_d;
      running     <= running_d;
      step_count  <= step_count_d;
      overruns    <= overruns_d;
      pause_deb_q <= pause_deb;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_LOAD: if (load_done) state_d = S_WAIT;
      S_WAIT: begin
        if (sel_changed)
          state_d = S_LOAD;
        else if (running && frame_tick) begin
          if (div_done) state_d = S_STEP;
        end else if (!running && step_press)
          state_d = S_STEP;
      end
      S_STEP: if (eng.step_done) state_d = S_WAIT;
      default: state_d = S_LOAD;
    endcase
  end

  // Next values of the registered outputs; a pause press toggles running in every state.
  always_comb begin
    load_cnt_d   = load_cnt;
    div_d        = div;
    scenario_d   = scenario;
    load_d       = load_q;
    step_req_d   = step_req_q;
    running_d    = running ^ pause_press;
    step_count_d = step_count;
    overruns_d   = overruns;
    case (state)
      S_LOAD: begin
        if (load_done) begin
          load_d     = 1'b0;
          load_cnt_d = '0;
        end else begin
          load_d     = 1'b1;
          load_cnt_d = load_cnt + LW'(1);
        end
      end
      S_WAIT: begin
        if (sel_changed) begin
          scenario_d   = sel_deb;
          load_cnt_d   = '0;
          div_d        = '0;
          step_req_d   = 1'b0;
          step_count_d = '0;
          overruns_d   = '0;
        end else if (running && frame_tick) begin
          if (div_done) begin
            div_d      = '0;
            step_req_d = 1'b1;
          end else begin
            div_d = div + DW'(1);
          end
        end else if (!running && step_press) begin
          step_req_d = 1'b1;
        end
      end
      S_STEP: begin
        if (eng.step_done) begin
          step_req_d   = 1'b0;
          step_count_d = step_count + 32'd1;
        end else if (frame_tick && (overruns != '1)) begin
          overruns_d = overruns + OVR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign eng.load     = load_q;
  assign eng.step_req = step_req_q;
endmodule

// File: tb/tb_sim_sequencer.sv
// tb/tb_sim_sequencer.sv - randomized self-checking bench for sim_sequencer against a counting model
module tb_sim_sequencer;
  localparam int DEBOUNCE    = 4;
  localparam int LOAD_CYCLES = 4;
  localparam int TICK_DIV    = 2;
  localparam int OVR_W       = 8;
  localparam int OVR_MAX     = (1 << OVR_W) - 1;

  logic             clock_162 = 1'b0;
  logic             rst, pause_btn, step_btn, frame_tick;
  logic [15:0]      sel, scenario;
  logic             running;
  logic [31:0]      step_count;
  logic [OVR_W-1:0] overruns;

  sim_sequencer_if eng ();

  sim_sequencer #(
    .DEBOUNCE(DEBOUNCE), .LOAD_CYCLES(LOAD_CYCLES), .TICK_DIV(TICK_DIV), .OVR_W(OVR_W)
  ) dut (
    .clock_162(clock_162), .rst(rst), .sel(sel), .pause_btn(pause_btn), .step_btn(step_btn),
    .frame_tick(frame_tick), .eng(eng), .scenario(scenario), .running(running),
    .step_count(step_count), .overruns(overruns)
  );

  always #5 clock_162 = ~clock_162;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of accepted ticks, finished steps, missed ticks, latched scenario.
  int          m_cnt_ticks = 0;
  int          m_steps = 0;
  int          m_ovr = 0;
  logic [15:0] m_scn = '0;
  logic        m_run = 1'b0;

  int   eng_delay = -1;
  int   eng_cnt = 0;
  int   req_rises = 0;
  int   load_rises = 0;
  logic prev_req = 1'b0;
  logic prev_load = 1'b0;

  // One clock; samples 1 ns after the edge and plays the engine side of the handshake.
  task automatic cyc();
    @(posedge clock_162);
    #1;
    if (eng.step_req && !prev_req) req_rises++;
    if (eng.load && !prev_load) load_rises++;
    prev_req  = eng.step_req;
    prev_load = eng.load;
    if (eng.step_done)
      eng.step_done = 1'b0;
    else if (eng.step_req && eng_delay >= 1) begin
      eng_cnt++;
      if (eng_cnt >= eng_delay) begin
        eng.step_done = 1'b1;
        eng_cnt = 0;
      end
    end
  endtask

  task automatic pulse_tick(output logic req_after);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    req_after = eng.step_req;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    repeat (10) cyc();
    pause_btn = 1'b0;
    repeat (10) cyc();
    m_run = ~m_run;
  endtask

  task automatic test_reset();
    logic exp_l;
    rst = 1'b1; sel = '0; pause_btn = 1'b0; step_btn = 1'b0; frame_tick = 1'b0;
    eng.step_done = 1'b0;
    repeat (3) cyc();
    n_vec++;
    if ({eng.load, eng.step_req, running, scenario, step_count, overruns} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got load=%b req=%b run=%b scn=%h cnt=%0d ovr=%0d required all zero",
               eng.load, eng.step_req, running, scenario, step_count, overruns);
    end
    rst = 1'b0;
    for (int i = 1; i <= LOAD_CYCLES + 2; i++) begin
      cyc();
      exp_l = (i <= LOAD_CYCLES);
      n_vec++;
      if (eng.load !== exp_l) begin
        n_err++;
        $display("FAIL reset_load_cycle%0d: got %b required %b", i, eng.load, exp_l);
      end
    end
    n_vec++;
    if ({running, eng.step_req, scenario} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got run=%b req=%b scn=%h required 0/0/0", running, eng.step_req, scenario);
    end
  endtask

  task automatic test_run_steps();
    logic req, exp_req;
    int   rr0, s0;
    press_pause();
    n_vec++;
    if (running !== m_run) begin
      n_err++;
      $display("FAIL pause_to_run: got %b required %b", running, m_run);
    end
    eng_delay = int'($urandom_range(1, 10));
    rr0 = req_rises;
    s0  = m_steps;
    for (int i = 0; i < 6; i++) begin
      pulse_tick(req);
      m_cnt_ticks++;
      exp_req = (m_cnt_ticks % TICK_DIV == 0);
      if (exp_req) m_steps++;
      n_vec++;
      if (req !== exp_req) begin
        n_err++;
        $display("FAIL run_tick%0d_req: got %b required %b", i, req, exp_req);
      end
      repeat ($urandom_range(30, 100)) cyc();
    end
    n_vec++;
    if (step_count !== 32'(m_steps) || overruns !== OVR_W'(m_ovr)) begin
      n_err++;
      $display("FAIL run_counts: got cnt=%0d ovr=%0d required cnt=%0d ovr=%0d",
               step_count, overruns, m_steps, m_ovr);
    end
    n_vec++;
    if (req_rises - rr0 !== m_steps - s0) begin
      n_err++;
      $display("FAIL run_req_pulses: got %0d required %0d", req_rises - rr0, m_steps - s0);
    end
  endtask

  task automatic test_overrun();
    logic req, exp_req;
    int   k;
    bit   ok;
    eng_delay = -1;
    for (int t = 0; t < TICK_DIV; t++) begin
      pulse_tick(req);
      m_cnt_ticks++;
      exp_req = (m_cnt_ticks % TICK_DIV == 0);
      n_vec++;
      if (req !== exp_req) begin
        n_err++;
        $display("FAIL ovr_arm_tick%0d: got %b required %b", t, req, exp_req);
      end
      repeat (3) cyc();
    end
    k = int'($urandom_range(2, 6));
    for (int j = 0; j < k; j++) begin
      repeat ($urandom_range(3, 15)) cyc();
      pulse_tick(req);
      if (m_ovr < OVR_MAX) m_ovr++;
      n_vec++;
      if (req !== 1'b1) begin
        n_err++;
        $display("FAIL ovr_req_held%0d: got %b required 1", j, req);
      end
    end
    n_vec++;
    if (overruns !== OVR_W'(m_ovr)) begin
      n_err++;
      $display("FAIL ovr_count: got %0d required %0d", overruns, m_ovr);
    end
    // step_done and frame_tick together: the step completes and the tick is neither missed nor counted
    eng.step_done = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    m_steps++;
    n_vec++;
    if (eng.step_req !== 1'b0 || overruns !== OVR_W'(m_ovr) || step_count !== 32'(m_steps)) begin
      n_err++;
      $display("FAIL ovr_done_with_tick: got req=%b ovr=%0d cnt=%0d required 0/%0d/%0d",
               eng.step_req, overruns, step_count, m_ovr, m_steps);
    end
    repeat (3) cyc();
    for (int t = 0; t < TICK_DIV; t++) begin
      pulse_tick(req);
      m_cnt_ticks++;
      exp_req = (m_cnt_ticks % TICK_DIV == 0);
      n_vec++;
      if (req !== exp_req) begin
        n_err++;
        $display("FAIL ovr_divider_after_done%0d: got %b required %b", t, req, exp_req);
      end
      if (!exp_req) repeat (3) cyc();
    end
    repeat (300) begin
      pulse_tick(req);
      if (m_ovr < OVR_MAX) m_ovr++;
    end
    n_vec++;
    if (overruns !== OVR_W'(m_ovr)) begin
      n_err++;
      $display("FAIL ovr_saturate: got %0d required %0d", overruns, m_ovr);
    end
    eng_delay = 2;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!eng.step_req) begin
        ok = 1'b1;
        break;
      end
    end
    m_steps++;
    n_vec++;
    if (ok !== 1'b1 || step_count !== 32'(m_steps)) begin
      n_err++;
      $display("FAIL ovr_release: got done=%b cnt=%0d required 1/%0d", ok, step_count, m_steps);
    end
  endtask

  task automatic test_scenario_defer();
    logic        req, exp_l;
    logic [15:0] v;
    eng_delay = -1;
    for (int t = 0; t < TICK_DIV; t++) begin
      pulse_tick(req);
      m_cnt_ticks++;
      repeat (3) cyc();
    end
    n_vec++;
    if (eng.step_req !== 1'b1) begin
      n_err++;
      $display("FAIL defer_step_issued: got %b required 1", eng.step_req);
    end
    v = m_scn ^ 16'($urandom_range(1, 65535));
    sel = v;
    repeat (10) cyc();
    n_vec++;
    if (scenario !== m_scn || eng.load !== 1'b0 || eng.step_req !== 1'b1) begin
      n_err++;
      $display("FAIL defer_hold: got scn=%h load=%b req=%b required %h/0/1",
               scenario, eng.load, eng.step_req, m_scn);
    end
    eng.step_done = 1'b1;
    cyc();
    n_vec++;
    if (scenario !== m_scn || eng.step_req !== 1'b0) begin
      n_err++;
      $display("FAIL defer_done_cycle: got scn=%h req=%b required %h/0", scenario, eng.step_req, m_scn);
    end
    cyc();
    m_scn = v; m_cnt_ticks = 0; m_steps = 0; m_ovr = 0;
    n_vec++;
    if (scenario !== m_scn || eng.load !== 1'b0) begin
      n_err++;
      $display("FAIL defer_latch: got scn=%h load=%b required %h/0", scenario, eng.load, m_scn);
    end
    for (int i = 0; i <= LOAD_CYCLES; i++) begin
      cyc();
      exp_l = (i < LOAD_CYCLES);
      n_vec++;
      if (eng.load !== exp_l) begin
        n_err++;
        $display("FAIL defer_load%0d: got %b required %b", i, eng.load, exp_l);
      end
    end
    n_vec++;
    if (step_count !== 32'(m_steps) || overruns !== OVR_W'(m_ovr)) begin
      n_err++;
      $display("FAIL defer_cleared: got cnt=%0d ovr=%0d required 0/0", step_count, overruns);
    end
  endtask

  task automatic test_sel_glitch();
    int lr0;
    lr0 = load_rises;
    sel = m_scn ^ 16'($urandom_range(1, 65535));
    repeat ($urandom_range(1, DEBOUNCE - 1)) cyc();
    sel = m_scn;
    repeat (20) cyc();
    n_vec++;
    if (scenario !== m_scn || load_rises !== lr0) begin
      n_err++;
      $display("FAIL glitch: got scn=%h loads=%0d required %h/0", scenario, load_rises - lr0, m_scn);
    end
  endtask

  task automatic test_sel_latency();
    logic [15:0] v2, exp_s;
    logic        exp_l;
    int          lat;
    lat = 2 + DEBOUNCE + 1;
    v2 = m_scn ^ 16'($urandom_range(1, 65535));
    sel = v2;
    for (int i = 1; i <= lat + 1; i++) begin
      cyc();
      exp_s = (i >= lat) ? v2 : m_scn;
      exp_l = (i == lat + 1);
      n_vec++;
      if (scenario !== exp_s || eng.load !== exp_l) begin
        n_err++;
        $display("FAIL sel_latency_cycle%0d: got scn=%h load=%b required %h/%b",
                 i, scenario, eng.load, exp_s, exp_l);
      end
    end
    repeat (LOAD_CYCLES + 4) cyc();
    m_scn = v2; m_cnt_ticks = 0; m_steps = 0; m_ovr = 0;
  endtask

  task automatic test_single_step();
    logic req;
    int   rr0, exp_ss;
`ifdef SIM_SINGLE_STEP_EN
    exp_ss = 1;
`else
    exp_ss = 0;
`endif
    press_pause();
    n_vec++;
    if (running !== m_run) begin
      n_err++;
      $display("FAIL pause_to_stop: got %b required %b", running, m_run);
    end
    rr0 = req_rises;
    for (int t = 0; t < TICK_DIV + 1; t++) begin
      pulse_tick(req);
      repeat (3) cyc();
    end
    n_vec++;
    if (req_rises !== rr0) begin
      n_err++;
      $display("FAIL paused_ticks_ignored: got %0d requests required 0", req_rises - rr0);
    end
    eng_delay = 3;
    step_btn = 1'b1;
    repeat (10) cyc();
    step_btn = 1'b0;
    repeat (20) cyc();
    m_steps += exp_ss;
    n_vec++;
    if (req_rises - rr0 !== exp_ss || step_count !== 32'(m_steps)) begin
      n_err++;
      $display("FAIL single_step: got reqs=%0d cnt=%0d required %0d/%0d",
               req_rises - rr0, step_count, exp_ss, m_steps);
    end
  endtask

  task automatic test_reset_midstep();
    logic req;
    int   lr0, exp_loads;
    press_pause();
    eng_delay = -1;
    m_cnt_ticks = 0;
    for (int t = 0; t < TICK_DIV; t++) begin
      pulse_tick(req);
      repeat (3) cyc();
    end
    n_vec++;
    if (eng.step_req !== 1'b1) begin
      n_err++;
      $display("FAIL midstep_req: got %b required 1", eng.step_req);
    end
    rst = 1'b1;
    cyc();
    m_run = 1'b0;
    n_vec++;
    if ({eng.step_req, eng.load, running, scenario, step_count, overruns} !== '0) begin
      n_err++;
      $display("FAIL midstep_reset: got req=%b load=%b run=%b scn=%h cnt=%0d ovr=%0d required all zero",
               eng.step_req, eng.load, running, scenario, step_count, overruns);
    end
    rst = 1'b0;
    lr0 = load_rises;
    exp_loads = (m_scn != 16'h0) ? 2 : 1;
    repeat (25) cyc();
    n_vec++;
    if (scenario !== m_scn || load_rises - lr0 !== exp_loads || running !== m_run) begin
      n_err++;
      $display("FAIL post_reset_relatch: got scn=%h loads=%0d run=%b required %h/%0d/%b",
               scenario, load_rises - lr0, running, m_scn, exp_loads, m_run);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_run_steps();
    test_overrun();
    test_scenario_defer();
    test_sel_glitch();
    test_sel_latency();
    test_single_step();
    test_reset_midstep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
